toggle_rx: RTL and testbench

TOGGLE_RX -- requirements
Module: toggle_rx

---
 rtl/toggle_rx.sv | 89 ++++++++
 tb/tb_toggle_rx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_rx.sv
// Receives events from a remote toggle (T-flop) line: sync, edge-detect, strobe, count, and track ack handshake.
// Latency: change before edge N -> evt_pulse after edge N+2. No backpressure: events arriving while pending set overrun.
module toggle_rx #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             t_in,
    input  logic             ack,
    output logic             evt_pulse,
    output logic             pending,
    output logic             overrun,
    output logic [CNT_W-1:0] count,
    output logic             armed
);

    typedef enum logic [1:0] {ARM, IDLE, PEND, OVR} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       s1;
    logic       s2;
    logic       s3;
    logic [1:0] arm_cnt;
    logic       det;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= t_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Detection stays off until s3 has been filled from real t_in samples.
    assign det = armed & en & (s2 ^ s3);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            arm_cnt <= 2'd0;
        end else if (state == ARM && arm_cnt != 2'd2) begin
            arm_cnt <= arm_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= ARM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARM:  if (arm_cnt == 2'd2) state_nxt = IDLE;
            IDLE: if (det) state_nxt = PEND;
            PEND: begin
                if (ack)      state_nxt = det ? PEND : IDLE;
                else if (det) state_nxt = OVR;
            end
            OVR:  if (ack) state_nxt = det ? PEND : IDLE;
            default: state_nxt = ARM;
        endcase
    end

    always_comb begin
        armed   = (state != ARM);
        pending = (state == PEND) || (state == OVR);
        overrun = (state == OVR);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            evt_pulse <= 1'b0;
            count     <= '0;
        end else begin
            evt_pulse <= det;
            if (det) count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_toggle_rx.sv
// Randomised and directed bench for toggle_rx against an event-schedule reference model.
module tb_toggle_rx;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             clr;
    logic             en;
    logic             t_in;
    logic             ack;
    logic             evt_pulse;
    logic             pending;
    logic             overrun;
    logic [CNT_W-1:0] count;
    logic             armed;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a line change sampled at edge N is due as an event at edge N+2;
    // it is accepted if en is high then and at least 4 edges have elapsed since release.
    int               m_edges;
    logic             m_last;
    int               due_q[$];
    logic             m_pulse;
    logic             m_pend;
    logic             m_ovr;
    logic [CNT_W-1:0] m_cnt;

    toggle_rx #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .clr       (clr),
        .en        (en),
        .t_in      (t_in),
        .ack       (ack),
        .evt_pulse (evt_pulse),
        .pending   (pending),
        .overrun   (overrun),
        .count     (count),
        .armed     (armed)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_edges = 0;
        m_last  = 1'b0;
        due_q.delete();
        m_pulse = 1'b0;
        m_pend  = 1'b0;
        m_ovr   = 1'b0;
        m_cnt   = '0;
    endtask

    function automatic logic [CNT_W+3:0] exp_vec();
        return {m_pulse, m_pend, m_ovr, (m_edges >= 3), m_cnt};
    endfunction

    function automatic logic [CNT_W+3:0] obs_vec();
        return {evt_pulse, pending, overrun, armed, count};
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit after it.
    task automatic step(input logic tv, input logic ev, input logic av);
        logic e;
        t_in = tv;
        en   = ev;
        ack  = av;
        @(posedge clk);
        if (!clr) begin
            model_reset();
        end else begin
            e = 1'b0;
            m_edges++;
            if (due_q.size() > 0 && due_q[0] == m_edges) begin
                void'(due_q.pop_front());
                e = ev && (m_edges >= 4);
            end
            if (tv != m_last) begin
                due_q.push_back(m_edges + 2);
                m_last = tv;
            end
            m_pulse = e;
            if (e) m_cnt = m_cnt + 1'b1;
            if (!m_pend || av) begin
                m_pend = e;
                m_ovr  = 1'b0;
            end else begin
                m_ovr = m_ovr | e;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b0; t_in = 1'b1; en = 1'b1; ack = 1'b0;
        model_reset();
        #2;
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1);
        clr = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b1, 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_release edge %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i == 3) begin
                n_cmp++;
                if (armed !== 1'b1) begin
                    n_bad++;
                    $display("FAIL armed_at_3rd_edge: got %b want 1", armed);
                end
            end
        end
    endtask

    task automatic test_single();
        int since;
        int lat;
        logic cur;
        cur = t_in;
        since = -1;
        lat = -1;
        for (int i = 1; i <= 9; i++) begin
            step((i == 1) ? ~cur : ((i > 1) ? ~cur : cur), 1'b1, (since == 2));
            if (evt_pulse === 1'b1 && lat < 0) lat = i;
            if (m_pulse) since = 0;
            else if (since >= 0) since++;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL single step %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (lat != 3) begin
            n_bad++;
            $display("FAIL single_latency: got %0d steps want 3", lat);
        end
    endtask

    task automatic test_overrun();
        logic cur;
        cur = t_in;
        for (int i = 1; i <= 10; i++) begin
            if (i == 1 || i == 6) cur = ~cur;
            step(cur, 1'b1, 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL overrun step %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (overrun !== 1'b1 || pending !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_set: got ovr=%b pend=%b want 1 1", overrun, pending);
        end
        step(cur, 1'b1, 1'b1);
        n_cmp++;
        if ({pending, overrun} !== 2'b00 || {pending, overrun} !== {m_pend, m_ovr}) begin
            n_bad++;
            $display("FAIL overrun_ack: got pend=%b ovr=%b want 0 0", pending, overrun);
        end
    endtask

    task automatic test_ack_same_cycle();
        logic cur;
        cur = t_in;
        for (int i = 1; i <= 8; i++) begin
            if (i == 1 || i == 5) cur = ~cur;
            step(cur, 1'b1, (i == 7));
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL ack_same step %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i == 7) begin
                n_cmp++;
                if (pending !== 1'b1 || overrun !== 1'b0 || evt_pulse !== 1'b1) begin
                    n_bad++;
                    $display("FAIL ack_same_det: got pend=%b ovr=%b pulse=%b want 1 0 1",
                             pending, overrun, evt_pulse);
                end
            end
        end
        step(cur, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back_wrap();
        int pulses;
        logic cur;
        clr = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        clr = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        cur = 1'b0;
        pulses = 0;
        for (int i = 0; i < 262; i++) begin
            if (i < 256) cur = ~cur;
            step(cur, 1'b1, 1'($urandom_range(0, 1)));
            if (evt_pulse === 1'b1) pulses++;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL b2b step %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (pulses != 256 || count !== '0) begin
            n_bad++;
            $display("FAIL wrap: got pulses=%0d count=%0d want 256 0", pulses, count);
        end
    endtask

    task automatic test_en_gate();
        logic cur;
        logic [CNT_W-1:0] c0;
        cur = t_in;
        c0 = count;
        for (int i = 1; i <= 7; i++) begin
            if (i == 1) cur = ~cur;
            step(cur, (i > 5), 1'b1);
            n_cmp++;
            if (evt_pulse !== 1'b0 || count !== c0 || obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL en_gate step %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 1; i <= 4; i++) begin
            if (i == 1) cur = ~cur;
            step(cur, 1'b1, 1'b0);
        end
        n_cmp++;
        if (count !== c0 + 1'b1) begin
            n_bad++;
            $display("FAIL en_gate_next: got count=%0d want %0d", count, c0 + 1'b1);
        end
    endtask

    task automatic test_random();
        logic cur;
        cur = t_in;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                clr = 1'b0;
                step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
                clr = 1'b1;
            end
            if ($urandom_range(0, 1) == 1) cur = ~cur;
            step(cur, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 3));
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random step %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_ack_same_cycle();
        test_back_to_back_wrap();
        test_en_gate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
